// File: rtl/aes_pkg.sv
// Shared AES controller types and sizing constants.
package aes_pkg;

  localparam int unsigned AES_NUM_ROUNDS = 10;
  localparam int unsigned AES_BLOCK_W    = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ADD_ONLY = 2'd0,
    FULL     = 2'd1,
    FINAL    = 2'd2
  } round_mode_t;

endpackage

// File: rtl/aes_round_controller.sv
// Iterative AES-128 encryption sequencer: owns the cipher state and walks it
// through the initial key addition, the full rounds and the final round.
module aes_round_controller
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out,
  output logic         key_req,
  output logic [3:0]   key_round,
  input  logic         key_ack,
  input  logic [127:0] round_key,
  output logic [127:0] dp_state,
  output logic [1:0]   dp_mode,
  input  logic [127:0] dp_result
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ctrl_state_t  state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] blk_q, blk_d;
  round_mode_t  mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

  // Key request and round index are decoded from registered state only, so
  // they change solely on the edge following an ack.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    busy      = 1'b0;
    done      = 1'b0;
    key_req   = 1'b0;
    key_round = '0;
    mode      = ADD_ONLY;
    case (state_q)
      IDLE: begin
        if (start) begin
          blk_d   = data_in;
          cnt_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        busy      = 1'b1;
        key_req   = 1'b1;
        key_round = cnt_q;
        if (cnt_q == '0)             mode = ADD_ONLY;
        else if (cnt_q == LAST_ROUND) mode = FINAL;
        else                          mode = FULL;
        if (key_ack) begin
          blk_d = dp_result;
          if (cnt_q == LAST_ROUND) state_d = DONE;
          else                     cnt_d   = cnt_q + 4'd1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dp_mode  = mode;
  assign dp_state = blk_q;
  assign data_out = blk_q;

endmodule

// File: tb/tb_aes_round_controller.sv
// Directed bench for aes_round_controller using an XOR-only datapath model.
module tb_aes_round_controller;
  import aes_pkg::*;

  localparam logic [127:0] PT = 128'h70b001506080c0300200b00c00ff0f0e;
  localparam logic [127:0] RK = 128'habec8a0381611515bbe003067830000c;
  localparam logic [127:0] CT = 128'hdb5c8b53e1e1d525b9e0b30a78cf0f02;
  localparam logic [127:0] ALT = 128'h0123456789abcdef0123456789abcdef;

  logic         clk = 1'b0;
  logic         rst, start, key_ack;
  logic [127:0] data_in, round_key, dp_state, dp_result, data_out;
  logic         busy, done, key_req;
  logic [3:0]   key_round;
  logic [1:0]   dp_mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign dp_result = dp_state ^ round_key;

  aes_round_controller #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .data_out(data_out),
    .key_req(key_req), .key_round(key_round), .key_ack(key_ack),
    .round_key(round_key), .dp_state(dp_state), .dp_mode(dp_mode),
    .dp_result(dp_result)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; key_ack = 1'b0;
    data_in = '0; round_key = '0;
    #2;
    tick(); tick();
    total++;
    if ({busy, done, key_req} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, key_req});
    end
    total++;
    if (data_out !== '0 || dp_state !== '0) begin
      bad++; $display("FAIL reset_data got=%h want=0", data_out);
    end
    total++;
    if (key_round !== 4'd0 || dp_mode !== 2'd0) begin
      bad++; $display("FAIL reset_idx got=%0d/%0d want=0/0", key_round, dp_mode);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    logic [1:0] exp_mode;
    data_in = PT; round_key = RK; key_ack = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      exp_mode = (r == 0) ? 2'd0 : (r == 10) ? 2'd2 : 2'd1;
      total++;
      if (key_req !== 1'b1 || key_round !== 4'(r)) begin
        bad++; $display("FAIL basic_key r=%0d got req=%b idx=%0d want req=1 idx=%0d",
                        r, key_req, key_round, r);
      end
      total++;
      if (dp_mode !== exp_mode) begin
        bad++; $display("FAIL basic_mode r=%0d got=%0d want=%0d", r, dp_mode, exp_mode);
      end
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL basic_busy r=%0d got busy=%b done=%b want 1/0", r, busy, done);
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || key_req !== 1'b0) begin
      bad++; $display("FAIL basic_done got done=%b busy=%b req=%b want 1/0/0", done, busy, key_req);
    end
    total++;
    if (data_out !== CT) begin
      bad++; $display("FAIL basic_ct got=%h want=%h", data_out, CT);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL basic_pulse got done=%b want=0", done);
    end
  endtask

  task automatic test_wait;
    int cyc;
    data_in = PT; round_key = RK; key_ack = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    repeat (4) begin tick(); cyc++; end
    key_ack = 1'b0;
    repeat (3) begin
      tick(); cyc++;
      total++;
      if (key_req !== 1'b1 || key_round !== 4'd4) begin
        bad++; $display("FAIL wait_hold got req=%b idx=%0d want 1/4", key_req, key_round);
      end
      total++;
      if (data_out !== PT) begin
        bad++; $display("FAIL wait_state got=%h want=%h", data_out, PT);
      end
    end
    key_ack = 1'b1;
    while (!done && cyc < 40) begin tick(); cyc++; end
    total++;
    if (cyc != 15) begin
      bad++; $display("FAIL wait_latency got=%0d want=15", cyc);
    end
    total++;
    if (data_out !== CT) begin
      bad++; $display("FAIL wait_ct got=%h want=%h", data_out, CT);
    end
    tick();
  endtask

  task automatic test_start_ignored;
    int cyc, ndone;
    data_in = PT; round_key = RK; key_ack = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    data_in = ALT;
    ndone = 0;
    for (cyc = 2; cyc <= 20; cyc++) begin
      start = (cyc == 5);
      tick();
      if (done) begin
        ndone++;
        total++;
        if (data_out !== CT) begin
          bad++; $display("FAIL ignore_ct got=%h want=%h", data_out, CT);
        end
      end
    end
    start = 1'b0;
    total++;
    if (ndone != 1) begin
      bad++; $display("FAIL ignore_done_count got=%0d want=1", ndone);
    end
    total++;
    if (busy !== 1'b0 || data_out !== CT) begin
      bad++; $display("FAIL ignore_after got busy=%b data=%h want 0/%h", busy, data_out, CT);
    end
  endtask

  task automatic test_reset_midflight;
    int cyc;
    data_in = PT; round_key = RK; key_ack = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (key_round != 4'd6 && cyc < 20) begin tick(); cyc++; end
    total++;
    if (key_round !== 4'd6) begin
      bad++; $display("FAIL rstmid_reach got idx=%0d want=6", key_round);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, key_req} !== 3'b000 || key_round !== 4'd0 || dp_mode !== 2'd0) begin
      bad++; $display("FAIL rstmid_ctrl got=%b idx=%0d mode=%0d want 000/0/0",
                      {busy, done, key_req}, key_round, dp_mode);
    end
    total++;
    if (data_out !== '0) begin
      bad++; $display("FAIL rstmid_data got=%h want=0", data_out);
    end
    tick();
    rst = 1'b0;
    data_in = '0; round_key = '0;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_stale got done=%b busy=%b want 0/0", done, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin tick(); cyc++; end
    total++;
    if (cyc != 12 || data_out !== '0) begin
      bad++; $display("FAIL rstmid_rerun got cyc=%0d data=%h want 12/0", cyc, data_out);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int nd, last, first;
    data_in = PT; round_key = RK; key_ack = 1'b1; start = 1'b1;
    nd = 0; last = 0; first = 0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      tick();
      total++;
      if ((busy && done) || (!busy && key_req)) begin
        bad++; $display("FAIL b2b_flags cyc=%0d got busy=%b done=%b req=%b", cyc, busy, done, key_req);
      end
      if (done) begin
        nd++;
        if (nd == 1) first = cyc;
        else begin
          total++;
          if (cyc - last != 13) begin
            bad++; $display("FAIL b2b_period got=%0d want=13", cyc - last);
          end
        end
        total++;
        if (data_out !== CT) begin
          bad++; $display("FAIL b2b_ct got=%h want=%h", data_out, CT);
        end
        last = cyc;
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    total++;
    if (nd != 3 || first != 12) begin
      bad++; $display("FAIL b2b_count got n=%0d first=%0d want 3/12", nd, first);
    end
  endtask

  task automatic test_ack_idle;
    key_ack = 1'b1; start = 1'b0; data_in = ALT;
    repeat (5) begin
      tick();
      total++;
      if ({busy, done, key_req} !== 3'b000 || data_out !== CT) begin
        bad++; $display("FAIL ack_idle got flags=%b data=%h want 000/%h",
                        {busy, done, key_req}, data_out, CT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_idle();
    test_wait();
    test_start_ignored();
    test_reset_midflight();
    test_back_to_back();
    test_ack_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_controller.md
# aes_round_controller

Iterative AES-128 encryption sequencer. Owns the 128-bit cipher state register and steps it through the initial key addition, nine full rounds and one final round. It fetches each round key from the key-schedule block over a req/ack handshake and drives the combinational round datapath (the add-round-key, sub-bytes, shift-rows and mix-columns chain) via a mode select. It sits between the top-level block interface and the round datapath / key expansion.

## Interface

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds after the initial key addition (AES-128).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to encrypt data_in; sampled only in IDLE.
- data_in  in  128  plaintext; latched on the cycle start is accepted.
- busy  out  1  high from the cycle after start is accepted until done; reset 0.
- done  out  1  one-cycle pulse when data_out becomes valid; reset 0.
- data_out  out  128  ciphertext; equals state register; reset 0.
- key_req  out  1  round-key request; reset 0.
- key_round  out  4  index of the requested key, 0..NUM_ROUNDS; reset 0.
- key_ack  in  1  round_key valid this cycle for key_round; ignored unless key_req=1.
- round_key  in  128  round key from the key schedule.
- dp_state  out  128  state fed to the round datapath (= state register).
- dp_mode  out  2  datapath mode: 0 = ADD_ONLY, 1 = FULL, 2 = FINAL (no mix-columns); reset 0.
- dp_result  in  128  combinational datapath result for (dp_state, round_key, dp_mode).

## Operation

- FSM states: IDLE, ROUND, DONE.
- IDLE: busy=0, key_req=0. When start=1, latch data_in into the state register, clear the round counter to 0, and go to ROUND.
- ROUND: key_req=1 and key_round = round counter.
  - dp_mode = ADD_ONLY when the counter is 0, FINAL when it equals NUM_ROUNDS, FULL otherwise.
  - On a cycle with key_ack=1: state register <= dp_result. If the counter equals NUM_ROUNDS, go to DONE; otherwise increment the counter.
  - key_ack=0: hold everything. key_req stays high and key_round stays stable (wait states are unbounded).
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- data_out holds the last ciphertext until the next start is accepted. It shows intermediate state while busy, so consumers use it only on or after done.
- Ignored inputs:
  - start while in ROUND or DONE.
  - key_ack while in IDLE or DONE.
- A start that is high on the DONE cycle is not accepted. It is accepted the following cycle if still high.
- Reset at any point forces IDLE, clears the counter and all outputs to 0, and abandons the encryption in flight.
- The round counter is 4 bits and never exceeds NUM_ROUNDS, so there is no wrap.

## Timing

- Start accepted at edge E0. key_req is high from after E0, with key_round=0.
- With key_ack tied high, the state updates at edges E1..E11 for rounds 0..10.
- DONE occupies the cycle after E11, so done is high between E11 and E12. Latency is 12 cycles from start to done.
- Each key_ack low cycle adds exactly one cycle of latency.
- busy=1 from after E0 through E11, and drops in the same cycle that done rises.
- The earliest back-to-back start is sampled at E13, giving a throughput of 13 cycles per block with no waits.
- The key_round/key_req pair only changes on the cycle after an ack, so the key schedule sees stable requests.

## Structure

- Shared package aes_pkg holds:
  - ctrl_state_t (IDLE, ROUND, DONE),
  - round_mode_t (ADD_ONLY, FULL, FINAL),
  - AES_NUM_ROUNDS = 10, AES_BLOCK_W = 128.
- Single module, with no sub-module. The counter and mode decode are inline. The round datapath and key schedule remain external.

## Test plan

- XOR-only bench datapath model (dp_result = dp_state ^ round_key), constant round_key 128'habec8a0381611515bbe003067830000c, key_ack=1, data_in 128'h70b001506080c0300200b00c00ff0f0e.
  - Stimulus: start.
  - Required: key_round steps 0..10, dp_mode goes 0, then 1 for rounds 1..9, then 2.
  - Required: done exactly 12 cycles after start, with data_out = 128'hdb5c8b53e1e1d525b9e0b30a78cf0f02 (11 XORs leave one net XOR).
- Same stimulus with key_ack low for 3 cycles during round 4.
  - Required: key_round holds at 4 and the state is unchanged during the wait.
  - Required: done at cycle 15 with the same data_out.
- Pulse start again at cycle 5 of an encryption with different data_in.
  - Required: ignored, the result is unchanged, and exactly one done pulse occurs.
- Assert rst at round 6, then release, then start with data_in=0 and round_key=0.
  - Required: all outputs return to 0 immediately on rst.
  - Required: the new run finishes with data_out=0 and no stale done.
- Hold start high continuously.
  - Required: done pulses every 13 cycles, busy is never high together with done, and key_req=0 in DONE/IDLE.
- Hold key_ack=1 in IDLE.
  - Required: no state change and data_out keeps the previous ciphertext.
